// File: rtl/operand_split_if.sv
// operand_split_if: word stream in, registered operand pair out
interface operand_split_if #(parameter int WIDTH = 32, parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_fast;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             fast;
  logic             sign_hint;
  logic             zero_hint;
  logic [CNT_W-1:0] pair_cnt;
  modport slave (
    input  in_valid, in_data, in_fast, flush, out_ready,
    output in_ready, out_valid, opa, opb, fast, sign_hint, zero_hint, pair_cnt
  );
  modport master (
    output in_valid, in_data, in_fast, flush, out_ready,
    input  in_ready, out_valid, opa, opb, fast, sign_hint, zero_hint, pair_cnt
  );
endinterface

// File: rtl/operand_split.sv
// operand_split: packs consecutive stream words into registered opa/opb pairs
module operand_split #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  operand_split_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] hold;
  logic             it, ot;
  assign bus.in_ready = !rst && !bus.flush && (state != FULL || bus.out_ready);
  assign it = bus.in_valid && bus.in_ready;
  assign ot = bus.out_valid && bus.out_ready;
  // hold keeps the next opa so the presented pair never changes while valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      hold          <= '0;
      bus.out_valid <= 1'b0;
      bus.opa       <= '0;
      bus.opb       <= '0;
      bus.fast      <= 1'b0;
      bus.sign_hint <= 1'b0;
      bus.zero_hint <= 1'b0;
      bus.pair_cnt  <= '0;
    end else begin
      if (ot) bus.pair_cnt <= bus.pair_cnt + 1'b1;
      if (state == EMPTY && it) begin
        hold  <= bus.in_data;
        state <= HALF;
      end
      if (state == HALF && bus.flush) state <= EMPTY;
      else if (state == HALF && it) begin
        bus.opa       <= hold;
        bus.opb       <= bus.in_data;
        bus.fast      <= bus.in_fast;
        bus.sign_hint <= hold[WIDTH-1] ^ bus.in_data[WIDTH-1];
        bus.zero_hint <= hold[WIDTH-2] | bus.in_data[WIDTH-2];
        bus.out_valid <= 1'b1;
        state         <= FULL;
      end
      if (state == FULL && ot) begin
        bus.out_valid <= 1'b0;
        state         <= it ? HALF : EMPTY;
        if (it) hold <= bus.in_data;
      end
    end
  end
endmodule

// File: doc/operand_split.md
# operand_split

Source side of the two-operand datapath interface: accepts a single stream of 32-bit words and packs consecutive word pairs into registered `opa`/`opb` operand pairs. Each pair carries a `fast` mode bit and two precomputed hint bits derived from operand bits 31 and 30. It sits between a serial operand source and any two-operand consumer that samples `opa`, `opb` and `fast` together.

## Interface
- `WIDTH`, default 32: operand width in bits; hints use bits `WIDTH-1` and `WIDTH-2`.
- `CNT_W`, default 8: width of the completed-pair counter.

Ports:
- `clk`  input  1: the single clock; all state is on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: block accepts `in_data` this cycle.
- `in_data`  input  `WIDTH`: operand word; first word of a pair is `opa`, second is `opb`.
- `in_fast`  input  1: mode bit, sampled only with the `opb` word.
- `flush`  input  1: discard a half-collected pair.
- `out_valid`  output  1: `opa`, `opb`, `fast` and hints hold a complete pair.
- `out_ready`  input  1: consumer takes the pair this cycle.
- `opa`  output  `WIDTH`: first operand.
- `opb`  output  `WIDTH`: second operand.
- `fast`  output  1: registered `in_fast` of the pair.
- `sign_hint`  output  1: `opa[WIDTH-1] ^ opb[WIDTH-1]`, registered with the pair.
- `zero_hint`  output  1: `opa[WIDTH-2] | opb[WIDTH-2]`, registered with the pair.
- `pair_cnt`  output  `CNT_W`: number of pairs handed off (`out_valid & out_ready`), wraps modulo 2^`CNT_W`.

## Operation
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- States:
  - EMPTY: no word held.
  - HALF: `opa` captured, waiting for `opb`.
  - FULL: pair presented.
- `in_ready` = `!flush & (state != FULL | out_ready)`.
  - `in_ready` is 0 while `rst` is high.
- EMPTY + input transfer: capture `in_data` into the `opa` holding register; go to HALF.
- HALF + input transfer:
  - Capture `in_data` into `opb` and `in_fast` into `fast`.
  - Compute both hints from the held `opa` and the incoming word.
  - Go to FULL; assert `out_valid`.
- FULL + output transfer without input transfer: go to EMPTY; clear `out_valid`.
- FULL + output transfer with a simultaneous input transfer: the new word becomes the next `opa`; go to HALF; clear `out_valid`.
- FULL without output transfer: all outputs hold stable (`in_ready` = 0).
- `flush`:
  - In HALF: drop the held `opa` and go to EMPTY. No input is accepted that cycle.
  - In FULL: the presented pair is unaffected (it is complete). No input is accepted that cycle.
  - In EMPTY: no effect.
- `opa` visible on the output updates only when the pair completes. The holding register for a new `opa` is separate, so output operands never change while `out_valid` = 1.
- `pair_cnt` increments by 1 on each output transfer; `2^CNT_W - 1` wraps to 0.
- Reset mid-operation: a partial or presented pair is lost; no output transfer is reported.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `opa` 0, `opb` 0, `fast` 0, `sign_hint` 0, `zero_hint` 0, `pair_cnt` 0, holding register 0.
- Latency: `opb` accepted at edge n, so `out_valid` = 1 and all pair outputs valid after edge n.
- Best throughput: one pair per 2 cycles when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready` and `flush` only. No combinational path runs from `in_valid`/`in_data` to any output.
- `out_valid` and all pair outputs are driven directly from registers.

## Test plan
- Reset, then A=`32'h8000_0000`, B=`32'h4000_0001`, `in_fast`=1 on consecutive cycles, `out_ready`=1:
  - `out_valid` rises 1 cycle after B.
  - `opa`=`8000_0000`, `opb`=`4000_0001`, `fast`=1, `sign_hint`=1, `zero_hint`=1.
  - `pair_cnt`=1 after handoff.
- Hold `out_ready`=0 after a pair, keep `in_valid`=1:
  - `in_ready`=0 and outputs stay stable for 10 cycles.
  - Raise `out_ready`: the same cycle accepts the next A; state goes to HALF.
- Send A=`32'h1234_5678`, pulse `flush`, then send C=`32'h0000_0001`, D=`32'h0000_0002`:
  - Output pair is C/D; `sign_hint`=0, `zero_hint`=0.
  - A never appears on the output.
- `flush` asserted with `in_valid`=1 while in FULL: `in_ready`=0, the pair is retained, and `pair_cnt` increments only on handoff.
- Stream 257 pairs with `CNT_W`=8: `pair_cnt` reads 1 at the end (wrap).
- Assert `rst` asynchronously while in HALF and again while in FULL:
  - All outputs go to 0 immediately without a clock edge.
  - After release, the next two words form a fresh pair.
